// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
// One operation in flight at a time; the result is held until its owner consumes it.
module alu_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_branch,
    input  logic [3:0]       req0_func3,
    input  logic [31:0]      req0_rs1,
    input  logic [31:0]      req0_rs2,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_branch,
    input  logic [3:0]       req1_func3,
    input  logic [31:0]      req1_rs1,
    input  logic [31:0]      req1_rs2,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_data,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_data,

    output logic             alu_branch,
    output logic [3:0]       alu_func3,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    input  logic [31:0]      alu_data_out,

    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_last_grant;
    logic [31:0]       r_result;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_any_valid;
    logic              w_winner;
    logic              w_drained;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_cnt0_max;
    logic              w_cnt1_max;

    assign w_any_valid = req0_valid | req1_valid;

    // w_winner is only meaningful when some request is valid; w_accept gates it.
    always_comb begin
        w_winner = 1'b0;
        if (PRIO_MODE == 1) begin
            w_winner = !req0_valid;
        end else if (req0_valid && req1_valid) begin
            w_winner = !r_last_grant;
        end else begin
            w_winner = !req0_valid;
        end
    end

    assign w_drained   = r_owner ? rsp1_ready : rsp0_ready;
    assign w_slot_free = (r_state == S_IDLE) || ((r_state == S_RESP) && w_drained);
    assign w_accept    = w_slot_free && w_any_valid;

    assign req0_ready  = w_accept && !w_winner;
    assign req1_ready  = w_accept &&  w_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_drained && !w_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // last_grant resets to 1 so that requester 0 is preferred first in round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_result     <= 32'd0;
        end else if (w_accept) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_result     <= alu_data_out;
        end
    end

    assign w_cnt0_max = (r_cnt0 == {CNT_W{1'b1}});
    assign w_cnt1_max = (r_cnt1 == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_winner && !w_cnt0_max) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_winner && !w_cnt1_max) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

    always_comb begin
        alu_branch = 1'b0;
        alu_func3  = 4'd0;
        alu_rs1    = 32'd0;
        alu_rs2    = 32'd0;
        if (w_accept) begin
            if (w_winner) begin
                alu_branch = req1_branch;
                alu_func3  = req1_func3;
                alu_rs1    = req1_rs1;
                alu_rs2    = req1_rs2;
            end else begin
                alu_branch = req0_branch;
                alu_func3  = req0_func3;
                alu_rs1    = req0_rs1;
                alu_rs2    = req0_rs2;
            end
        end
    end

    // Response outputs decode straight from state so reset clears them without a clock.
    assign rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == S_RESP) &&  r_owner;
    assign rsp0_data  = rsp0_valid ? r_result : 32'd0;
    assign rsp1_data  = rsp1_valid ? r_result : 32'd0;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 wins.
REQ-002 Parameter: CNT_W, 16, width of per-requester saturating grant counters.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-008 reqN_branch  input  1  requester N branch-compare select.
REQ-009 reqN_func3  input  4  requester N operation code (ALU sel encoding).
REQ-010 reqN_rs1, reqN_rs2  input  32  requester N operands.
REQ-011 rspN_valid  output  1  result available for requester N.
REQ-012 rspN_ready  input  1  requester N consumes result.
REQ-013 rspN_data  output  32  result for requester N.
REQ-014 alu_branch, alu_func3, alu_rs1, alu_rs2  output  1/4/32/32  drive shared combinational ALU.
REQ-015 alu_data_out  input  32  shared ALU result.
REQ-016 grant_cnt0, grant_cnt1  output  CNT_W  accepted-operation counts per requester.

Function
REQ-017 The block SHALL have states IDLE and RESP plus registers owner (1 bit), last_grant (1 bit), result (32 bits).
REQ-018 The block SHALL be able to accept ("slot free") when state=IDLE, or state=RESP and rsp[owner]_valid & rsp[owner]_ready.
REQ-019 Arbitration with PRIO_MODE=0: single valid wins; both valid -> requester != last_grant wins.
REQ-020 Arbitration with PRIO_MODE=1: req0 wins whenever valid; req1 only when req0_valid=0.
REQ-021 reqN_ready SHALL be 1 only when slot free and N is the winner; at most one ready high per cycle.
REQ-022 The ALU ports SHALL carry the winner's branch/func3/rs1/rs2 combinationally when slot free and any valid; otherwise all zero.
REQ-023 On accept edge: result<=alu_data_out, owner<=winner, last_grant<=winner, state<=RESP, grant_cntN increments.
REQ-024 Latency: rspN_valid SHALL rise the cycle after reqN_valid&reqN_ready; one accepted op per cycle max (back-to-back when drained).
REQ-025 In RESP: rsp[owner]_valid=1, rsp[owner]_data=result; other rsp valid=0, other rsp data=0.
REQ-026 RESP with rsp[owner]_ready=0: result, owner and rsp outputs SHALL hold; no new accept.
REQ-027 RESP drained with no accept SHALL go to IDLE; drained with accept SHALL stay RESP with new owner/result.
REQ-028 func3 codes with no ALU operation (10,11,12,14,15) SHALL be accepted normally; result is whatever ALU returns (0).
REQ-029 grant_cntN SHALL saturate at 2^CNT_W-1, never wrap.
REQ-030 reqN_valid deasserted before ready SHALL be legal; nothing captured.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, owner=0, last_grant=1, result=0, grant counters=0, all rsp valid=0, all rsp data=0.
REQ-032 Reset mid-RESP SHALL discard pending result; first cycle after release behaves as IDLE with req0 preferred.

Verification
REQ-033 req0 ADD (branch=0, func3=0, rs1=5, rs2=7) -> req0_ready same cycle, rsp0_valid next cycle, rsp0_data=12, grant_cnt0=1.
REQ-034 PRIO_MODE=0, both valid continuously, rsp ready=1 -> grants 0,1,0,1 each cycle; grant counters equal after even count.
REQ-035 req1 BLT (branch=1, func3=4, rs1=0xFFFFFFFF, rs2=1) with rsp1_ready=0 for 3 cycles -> rsp1_data=1 held stable, req0/req1 ready=0 meanwhile.
REQ-036 PRIO_MODE=1, both valid for 4 cycles -> only req0 granted; req1_ready stays 0.
REQ-037 Assert rst_n=0 during RESP with rsp0_data=12 -> rsp0_valid=0, rsp0_data=0 asynchronously; counters=0.
REQ-038 CNT_W=2, 5 accepts on req0 -> grant_cnt0=3 after 3rd accept and stays 3.
